// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA raster constants: default 640x480@60 geometry, bus widths, RGB pixel layout.
// Pure declarations, no logic; imported by the timing generator and the draw_* renderers.
// Renderers use the same bounds so every module agrees on what "on screen" means.
package vga_timing_gen_pkg;

  // Default 640x480@60 timing from a 100 MHz system clock
  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Coordinate and colour widths; 799 < 2^11 and 524 < 2^10 for the defaults
  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 10;
  localparam int unsigned RGB_W    = 4;
  localparam int unsigned PIXEL_W  = 3 * RGB_W;

  // Pixel word as returned by the draw modules: {R,G,B}
  typedef struct packed {
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_timing_gen_div.sv
// Pixel-clock divider: counts system clocks 0..CLK_DIV-1 and flags the last one.
// adv_o is combinational (counters advance on that edge); pix_tick_o is its registered copy.
// No backpressure; free-running from reset release, first advance CLK_DIV clocks after release.
module vga_timing_gen_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic adv_o,
  output logic pix_tick_o
);

  localparam int unsigned         DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             pix_tick_q;

  assign adv_o      = (div_q == DIV_LAST);
  assign pix_tick_o = pix_tick_q;

  // Next divider value: wrap to zero after the last clock of a pixel period
  always_comb begin
    div_d = adv_o ? '0 : div_q + DIV_W'(1);
  end

  // Divider state and the strobe that coincides with the counter update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      pix_tick_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      pix_tick_q <= adv_o;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: hcount/vcount for the renderers, sync decode, blanked RGB pins, frame_end strobe.
// Pins lag the counters by exactly one pixel tick; pixel input is sampled one tick after its coordinate.
// No backpressure: the raster free-runs; renderers must return a pixel within one pixel period.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PIXEL_W-1:0]  pixel,
  output logic [HCOUNT_W-1:0] hcount,
  output logic [VCOUNT_W-1:0] vcount,
  output logic                pix_tick,
  output logic                active,
  output logic                frame_end,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic [RGB_W-1:0]    vga_r,
  output logic [RGB_W-1:0]    vga_g,
  output logic [RGB_W-1:0]    vga_b
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Compare constants in counter widths
  localparam logic [HCOUNT_W-1:0] H_LAST   = HCOUNT_W'(H_TOTAL - 1);
  localparam logic [HCOUNT_W-1:0] H_VIS    = HCOUNT_W'(H_ACTIVE);
  localparam logic [HCOUNT_W-1:0] H_SY_BEG = HCOUNT_W'(H_ACTIVE + H_FP);
  localparam logic [HCOUNT_W-1:0] H_SY_END = HCOUNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCOUNT_W-1:0] V_LAST   = VCOUNT_W'(V_TOTAL - 1);
  localparam logic [VCOUNT_W-1:0] V_VIS    = VCOUNT_W'(V_ACTIVE);
  localparam logic [VCOUNT_W-1:0] V_SY_BEG = VCOUNT_W'(V_ACTIVE + V_FP);
  localparam logic [VCOUNT_W-1:0] V_SY_END = VCOUNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic                adv;
  logic [HCOUNT_W-1:0] hcount_q, hcount_d;
  logic [VCOUNT_W-1:0] vcount_q, vcount_d;
  logic                h_wrap, v_wrap;
  logic                vis_c, hs_c, vs_c;
  logic                run_q;
  logic                frame_end_q;
  logic                hs_q, vs_q;
  rgb_t                rgb_q;

  vga_timing_gen_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv_o      (adv),
    .pix_tick_o (pix_tick)
  );

  // Raster stepping and counter-stage decode of visibility and sync
  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    v_wrap   = (vcount_q == V_LAST);
    hcount_d = h_wrap ? '0 : hcount_q + HCOUNT_W'(1);
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = v_wrap ? '0 : vcount_q + VCOUNT_W'(1);
    end
    vis_c = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    hs_c  = !((hcount_q >= H_SY_BEG) && (hcount_q < H_SY_END));
    vs_c  = !((vcount_q >= V_SY_BEG) && (vcount_q < V_SY_END));
  end

  // Counters advance on the divider edge; frame_end marks the (0,0) arrival.
  // run_q holds active low until the raster has actually started after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      run_q       <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      frame_end_q <= adv && h_wrap && v_wrap;
      if (adv) begin
        hcount_q <= hcount_d;
        vcount_q <= vcount_d;
        run_q    <= 1'b1;
      end
    end
  end

  // Pin stage: captures the outgoing coordinate's sync and (blanked) pixel, one tick behind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb_q <= '0;
    end else if (adv) begin
      hs_q  <= hs_c;
      vs_q  <= vs_c;
      rgb_q <= vis_c ? rgb_t'(pixel) : '0;
    end
  end

  assign hcount    = hcount_q;
  assign vcount    = vcount_q;
  assign active    = run_q && vis_c;
  assign frame_end = frame_end_q;
  assign vga_hs    = hs_q;
  assign vga_vs    = vs_q;
  assign vga_r     = rgb_q.r;
  assign vga_g     = rgb_q.g;
  assign vga_b     = rgb_q.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny-geometry instance side by side.
// Expected values come from tick arithmetic on the number of clocks since reset release.
// Pixel input is constant red early on, then random; async resets are dropped mid clock-high.
module tb_vga_timing_gen;

  typedef struct {
    int div;
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
  } geo_t;

  typedef struct {
    int          e;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } mdl_t;

  localparam int NCYC = 12000;

  geo_t ga = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
  geo_t gb = '{2, 8, 2, 2, 2, 4, 1, 1, 1};

  logic        clk = 1'b0;
  logic        rst_a_n, rst_b_n;
  logic [11:0] pixel;

  logic [10:0] hc_a, hc_b;
  logic [9:0]  vc_a, vc_b;
  logic        pt_a, pt_b, act_a, act_b, fe_a, fe_b;
  logic        hs_a, hs_b, vs_a, vs_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

  mdl_t ma = '{0, 1'b1, 1'b1, 12'h000};
  mdl_t mb = '{0, 1'b1, 1'b1, 12'h000};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_a_n), .pixel(pixel),
    .hcount(hc_a), .vcount(vc_a), .pix_tick(pt_a), .active(act_a), .frame_end(fe_a),
    .vga_hs(hs_a), .vga_vs(vs_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_b_n), .pixel(pixel),
    .hcount(hc_b), .vcount(vc_b), .pix_tick(pt_b), .active(act_b), .frame_end(fe_b),
    .vga_hs(hs_b), .vga_vs(vs_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: one clock edge of a raster whose tick index is clocks/div.
  // At each tick the pins take the look of the position that was just left.
  function automatic mdl_t step(input mdl_t m, input logic rst, input logic [11:0] px, input geo_t g);
    int ht, vt, p, hp, vp;
    mdl_t n = m;
    ht = g.ha + g.hf + g.hs + g.hb;
    vt = g.va + g.vf + g.vs + g.vb;
    if (!rst) begin
      n.e = 0; n.hs = 1'b1; n.vs = 1'b1; n.rgb = 12'h000;
    end else begin
      n.e = m.e + 1;
      if (n.e % g.div == 0) begin
        p  = n.e / g.div - 1;
        hp = p % ht;
        vp = (p / ht) % vt;
        n.hs  = !(hp >= g.ha + g.hf && hp < g.ha + g.hf + g.hs);
        n.vs  = !(vp >= g.va + g.vf && vp < g.va + g.vf + g.vs);
        n.rgb = (hp < g.ha && vp < g.va) ? px : 12'h000;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ma <= step(ma, rst_a_n, pixel, ga);
    mb <= step(mb, rst_b_n, pixel, gb);
  end

  task automatic check_dut(input string nm, input geo_t g, input mdl_t m, input logic rst,
                           input logic [10:0] hc, input logic [9:0] vc, input logic pt,
                           input logic act, input logic fe, input logic hs, input logic vs,
                           input logic [11:0] rgb);
    int ht, vt, e, t, h, v;
    logic tick;
    ht   = g.ha + g.hf + g.hs + g.hb;
    vt   = g.va + g.vf + g.vs + g.vb;
    e    = rst ? m.e : 0;
    t    = e / g.div;
    h    = t % ht;
    v    = (t / ht) % vt;
    tick = (e > 0) && (e % g.div == 0);
    chk({nm, ".hcount"},    32'(hc),  32'(h));
    chk({nm, ".vcount"},    32'(vc),  32'(v));
    chk({nm, ".pix_tick"},  32'(pt),  32'(tick));
    chk({nm, ".active"},    32'(act), 32'((e >= g.div) && h < g.ha && v < g.va));
    chk({nm, ".frame_end"}, 32'(fe),  32'(tick && (t % (ht * vt) == 0)));
    chk({nm, ".vga_hs"},    32'(hs),  32'(rst ? m.hs : 1'b1));
    chk({nm, ".vga_vs"},    32'(vs),  32'(rst ? m.vs : 1'b1));
    chk({nm, ".rgb"},       32'(rgb), 32'(rst ? m.rgb : 12'h000));
  endtask

  task automatic check_a();
    check_dut("A", ga, ma, rst_a_n, hc_a, vc_a, pt_a, act_a, fe_a, hs_a, vs_a, {r_a, g_a, b_a});
  endtask

  task automatic check_b();
    check_dut("B", gb, mb, rst_b_n, hc_b, vc_b, pt_b, act_b, fe_b, hs_b, vs_b, {r_b, g_b, b_b});
  endtask

  initial begin
    int rb1, rb2, ra1;
    rb1 = 700 + int'($urandom_range(200, 0));
    rb2 = 6000 + int'($urandom_range(300, 0));
    ra1 = 9000 + int'($urandom_range(500, 0));
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    pixel   = 12'hF00;
    repeat (3) @(negedge clk);
    check_a();
    check_b();
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      check_a();
      check_b();
      if (c >= 4000 && $urandom_range(1, 0) == 1) pixel = 12'($urandom);
      if (c == rb1 + 7 || c == rb2 + 7) rst_b_n = 1'b1;
      if (c == ra1 + 9) rst_a_n = 1'b1;
      if (c == rb1 || c == rb2) begin
        @(posedge clk);
        #2 rst_b_n = 1'b0;
        #1 check_b();
      end
      if (c == ra1) begin
        @(posedge clk);
        #2 rst_a_n = 1'b0;
        #1 check_a();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
